pipelined_cla_addsub: RTL and testbench
=======================================

Name: pipelined_cla_addsub

Overview:
- Parametrised successor to the lab's single-cycle 4-bit carry-lookahead adder.
- Adds or subtracts WIDTH-bit operands as a pipeline of BLOCK-bit CLA slices, with one slice per stage and the carry registered between stages.
- Uses a valid/ready handshake on both sides.
- Produces carry, signed-overflow and zero flags.
- Sits between the operand register file and the result bus in the lab datapath.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of BLOCK, otherwise elaboration fails via $error.
- BLOCK, 4, CLA slice width in bits.
- NBLK, WIDTH/BLOCK (localparam), number of pipeline stages, which is also the latency.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- op_sub  in  1  0 = A+B, 1 = A-B
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sum  out  WIDTH  result
- carry_out  out  1  carry out of the MSB; for subtraction, 1 = no borrow
- overflow  out  1  signed overflow
- zero  out  1  sum == 0
- sat  out  1  result was clamped (CLA_SAT_EN only; tied 0 otherwise)

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is asynchronous and active-low (reset_n).
  - During reset, all stage valid bits clear and sum/carry_out/overflow/zero/sat go to 0.
  - out_valid = 0 and in_ready = 1 from the first clock after release.
- Subtraction: stage 0 loads B inverted and carry-in 1. For addition, stage 0 loads B and carry-in 0.
- Stage k (0..NBLK-1):
  - Computes slice k with the CLA equations G = A&B, P = A^B, C[i+1] = G[i] | P[i]&C[i].
  - Registers the slice sum, the slice carry-out and the remaining upper operand bits.
  - Lower slices already computed are carried forward unchanged.
- Final stage derives:
  - carry_out = C[WIDTH].
  - overflow = C[WIDTH] ^ C[WIDTH-1]. Stage NBLK-1 registers the MSB-1 carry for this.
  - zero = ~|sum.
- Handshake: global-stall pipeline.
  - advance = ~out_valid | out_ready.
  - in_ready = advance (combinational).
  - Transfer occurs when in_valid & in_ready. On advance, every stage shifts by one.
  - Without stall, latency = NBLK cycles from accept to out_valid. Throughput = 1 beat/cycle.
  - Bubbles are not collapsed; an empty stage shifts as a bubble.
- Stall: while out_valid & ~out_ready, all stage registers and outputs hold and in_ready = 0. No beat is lost or duplicated.
- Output data is stable while out_valid & ~out_ready.
- Simultaneous accept and emit in the same cycle are both legal.
- Reset mid-operation: all in-flight beats are discarded. No partial result is ever emitted.
- Wrap-around: sum is modulo 2^WIDTH; carry_out reports the lost bit.

Optional Feature:
- Macro: CLA_SAT_EN.
- Defined:
  - Final stage clamps signed results on overflow: positive overflow gives 2^(WIDTH-1)-1, negative overflow gives -2^(WIDTH-1).
  - Sign is taken from the effective A MSB.
  - sat = overflow. Flags carry_out and overflow still reflect the unclamped arithmetic. zero reflects the clamped sum.
- Undefined: sum is wrapped and sat is tied 0. The port list is identical in both builds.

Decomposition:
- Package cla_pkg:
  - localparams for defaults (CLA_WIDTH_DEF = 16, CLA_BLOCK_DEF = 4).
  - typedef enum logic {OP_ADD, OP_SUB} cla_op_e.
  - Packed struct cla_flags_t {carry, ovf, zero, sat}.
- Sub-module cla_slice:
  - Combinational, parametrised BLOCK.
  - Inputs a, b, cin. Outputs s, cout, c_msb (carry into its MSB).
  - Instantiated NBLK times by a generate loop. Top level owns all registers and the handshake.

Test Plan (WIDTH=16, BLOCK=4):
- add 0x1234+0x4321, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x5555, carry_out=0, overflow=0, zero=0.
- add 0xFFFF+0x0001 -> sum=0x0000, carry_out=1, zero=1, overflow=0.
- sub 0x8000-0x0001 -> sum=0x7FFF, carry_out=1, overflow=1. With CLA_SAT_EN: sum=0x8000, sat=1.
- add 0x7FFF+0x0001 -> sum=0x8000, overflow=1. With CLA_SAT_EN: sum=0x7FFF, sat=1, zero=0.
- Back-to-back 6 random ops, out_ready held low 3 cycles mid-stream -> in_ready=0 while stalled; all 6 results emitted in order, matching a scoreboard, with no duplicates.
- 3 beats in flight, reset_n pulsed low asynchronously mid-cycle -> outputs 0 immediately; after release no result emitted until a new beat is accepted, and it appears 4 cycles later.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared defaults, opcode and flag types for the pipelined CLA add/sub
package cla_pkg;

    localparam int CLA_WIDTH_DEF = 16;
    localparam int CLA_BLOCK_DEF = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } cla_op_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic sat;
    } cla_flags_t;

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational BLOCK-bit carry-lookahead slice
module cla_slice #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s     = p ^ c[BLOCK-1:0];
    assign cout  = c[BLOCK];
    assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - WIDTH-bit add/sub, one CLA slice per pipeline stage, global-stall handshake
// Optional: define CLA_SAT_EN to clamp signed results on overflow.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH_DEF,
    parameter int BLOCK = CLA_BLOCK_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sat
);

    localparam int NBLK = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0 || NBLK < 1) begin : g_bad_cfg
        $error("pipelined_cla_addsub: WIDTH (%0d) must be a multiple of BLOCK (%0d)", WIDTH, BLOCK);
    end

    cla_op_e          op;
    logic             advance;
    logic [NBLK-1:0]  valid_q;

    assign op        = op_sub ? OP_SUB : OP_ADD;
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[NBLK-1];

    // Bubbles shift like beats; nothing is collapsed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= (valid_q << 1) | NBLK'(in_valid);
        end
    end

    for (genvar k = 0; k < NBLK; k++) begin : stage
        localparam int REM = WIDTH - k * BLOCK;

        logic [REM-1:0]         a_i;
        logic [REM-1:0]         b_i;
        logic                   c_i;
        logic [BLOCK-1:0]       s_sl;
        logic                   co;
        logic                   cm;
        logic [(k+1)*BLOCK-1:0] s_n;

        if (k == 0) begin : g_in
            assign a_i = a;
            assign b_i = (op == OP_SUB) ? ~b : b;
            assign c_i = (op == OP_SUB);
            assign s_n = s_sl;
        end else begin : g_link
            assign a_i = stage[k-1].g_reg.a_q;
            assign b_i = stage[k-1].g_reg.b_q;
            assign c_i = stage[k-1].g_reg.c_q;
            assign s_n = {s_sl, stage[k-1].g_reg.s_q};
        end

        if (k == NBLK - 1) begin : g_last_slice
            cla_slice #(.BLOCK(BLOCK)) u_slice (
                .a     (a_i[BLOCK-1:0]),
                .b     (b_i[BLOCK-1:0]),
                .cin   (c_i),
                .s     (s_sl),
                .cout  (co),
                .c_msb (cm)
            );
        end else begin : g_mid_slice
            assign cm = 1'b0;
            cla_slice #(.BLOCK(BLOCK)) u_slice (
                .a     (a_i[BLOCK-1:0]),
                .b     (b_i[BLOCK-1:0]),
                .cin   (c_i),
                .s     (s_sl),
                .cout  (co),
                .c_msb ()
            );
        end

        // Only the operand bits still to be summed travel to the next stage.
        if (k < NBLK - 1) begin : g_reg
            logic [REM-BLOCK-1:0]   a_q;
            logic [REM-BLOCK-1:0]   b_q;
            logic [(k+1)*BLOCK-1:0] s_q;
            logic                   c_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (advance) begin
                    a_q <= a_i[REM-1:BLOCK];
                    b_q <= b_i[REM-1:BLOCK];
                    s_q <= s_n;
                    c_q <= co;
                end
            end
        end
    end

    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_fin;
    logic             c_fin;
    logic             v_fin;
    logic             sat_fin;
    cla_flags_t       flags_d;
    cla_flags_t       flags_q;
    logic [WIDTH-1:0] sum_q;

    assign sum_raw = stage[NBLK-1].s_n;
    assign c_fin   = stage[NBLK-1].co;
    assign v_fin   = stage[NBLK-1].co ^ stage[NBLK-1].cm;

`ifdef CLA_SAT_EN
    logic sign_a;
    // Overflow implies both effective operands share a sign, so A's MSB picks the rail.
    assign sign_a  = stage[NBLK-1].a_i[BLOCK-1];
    assign sum_fin = !v_fin ? sum_raw
                   : (sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
    assign sat_fin = v_fin;
`else
    assign sum_fin = sum_raw;
    assign sat_fin = 1'b0;
`endif

    always_comb begin
        flags_d       = '0;
        flags_d.carry = c_fin;
        flags_d.ovf   = v_fin;
        flags_d.zero  = ~|sum_fin;
        flags_d.sat   = sat_fin;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q   <= '0;
            flags_q <= '0;
        end else if (advance) begin
            sum_q   <= sum_fin;
            flags_q <= flags_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = flags_q.carry;
    assign overflow  = flags_q.ovf;
    assign zero      = flags_q.zero;
    assign sat       = flags_q.sat;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - directed vector table plus stall and mid-flight reset sequences
module tb_pipelined_cla_addsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         sat;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(W), .BLOCK(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sat       (sat)
    );

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        v;
        logic        z;
        logic        s;
    } res_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t clamp(input logic [15:0] a_v, input res_t r);
        res_t o;
        o = r;
`ifdef CLA_SAT_EN
        if (r.v) begin
            o.sum = a_v[15] ? 16'h8000 : 16'h7FFF;
            o.z   = 1'b0;
            o.s   = 1'b1;
        end
`else
        if (a_v === 16'hxxxx) o.s = 1'b0;
`endif
        return o;
    endfunction

    function automatic res_t model(input logic op, input logic [15:0] a_v, input logic [15:0] b_v);
        logic [16:0] t;
        res_t r;
        t     = {1'b0, a_v} + {1'b0, (op ? ~b_v : b_v)} + 17'(op);
        r.sum = t[15:0];
        r.c   = t[16];
        r.v   = op ? ((a_v[15] != b_v[15]) && (r.sum[15] != a_v[15]))
                   : ((a_v[15] == b_v[15]) && (r.sum[15] != a_v[15]));
        r.z   = (r.sum == 16'h0000);
        r.s   = 1'b0;
        return clamp(a_v, r);
    endfunction

    function automatic res_t dut_res();
        return {sum, carry_out, overflow, zero, sat};
    endfunction

    task automatic send_one(input logic op, input logic [15:0] a_v, input logic [15:0] b_v,
                            output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        op_sub   = op;
        a        = a_v;
        b        = b_v;
        #1;
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    vec_t tbl[12];
    res_t exp_q[$];

    initial begin
        int lat;
        res_t er;
        logic [15:0] ra[6];
        logic [15:0] rb[6];
        logic        rop[6];
        int sent;
        int got;
        int extra;
        logic        was_stalled;
        logic [15:0] held;

        tbl[0]  = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 16'h00FF, 16'h0F01, 16'h1000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("reset_outputs", {out_valid, sum, carry_out, overflow, zero, sat}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_out_valid", out_valid, 0);
        check("post_reset_in_ready", in_ready, 1);

        foreach (tbl[i]) begin
            send_one(tbl[i].op, tbl[i].a, tbl[i].b, lat);
            er = clamp(tbl[i].a, '{tbl[i].sum, tbl[i].c, tbl[i].v, tbl[i].z, 1'b0});
            check($sformatf("latency[%0d]", i), lat, 4);
            check($sformatf("result[%0d]", i), dut_res(), er);
        end

        // Six back-to-back beats with out_ready dropped for three cycles mid-stream.
        for (int i = 0; i < 6; i++) begin
            ra[i]  = 16'($urandom);
            rb[i]  = 16'($urandom);
            rop[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        got = 0;
        extra = 0;
        was_stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (sent < 6) begin
                in_valid = 1'b1;
                op_sub   = rop[sent];
                a        = ra[sent];
                b        = rb[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                if (was_stalled) check("stall_hold_sum", sum, held);
                held = sum;
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_output", 1, 0);
                end else begin
                    er = exp_q.pop_front();
                    check($sformatf("stream[%0d]", got), dut_res(), er);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(rop[sent], ra[sent], rb[sent]));
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("stream_results", got, 6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("stream_no_duplicates", extra, 0);

        // Four beats in, first held at the output, three still in flight when reset hits.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op_sub   = 1'b0;
            a        = (i == 0) ? 16'h1234 : 16'h1111 * 16'(i);
            b        = (i == 0) ? 16'h4321 : 16'h0001;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_valid_sum", {out_valid, sum}, {1'b1, 16'h5555});
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {out_valid, sum, carry_out, overflow, zero, sat}, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("post_reset_no_output", extra, 0);
        send_one(1'b0, 16'h0100, 16'h0020, lat);
        check("post_reset_latency", lat, 4);
        check("post_reset_result", dut_res(), model(1'b0, 16'h0100, 16'h0020));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
        $fatal(1, "timeout");
    end

endmodule
